// File: rtl/edge_mask_writer.sv
// Packs the 1-bit edge decision stream into WORD_W-pixel words and writes them
// to the edge-mask frame memory through a 2-entry valid/ready output queue.
module edge_mask_writer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 15,
  parameter int LATENCY = 1
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              in_valid,
  input  logic              sdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              frame_done,
  output logic              overflow
);

  localparam int                IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [9:0]        H_LIM     = 10'(H_RES);
  localparam logic [9:0]        V_LIM     = 10'(V_RES);
  localparam logic [9:0]        WORD_C    = 10'(WORD_W);
  localparam logic [ADDR_W-1:0] WPL_C     = ADDR_W'(H_RES / WORD_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES / WORD_W - 1);

  logic [9:0] xd, yd;

  // Coordinate delay line: realigns x/y with the late-arriving sdata.
  generate
    if (LATENCY == 0) begin : g_nodly
      assign xd = x_pixel;
      assign yd = y_pixel;
    end else begin : g_dly
      logic [9:0] x_dly_q [LATENCY];
      logic [9:0] y_dly_q [LATENCY];
      always_ff @(posedge pclk) begin
        if (reset) begin
          for (int i = 0; i < LATENCY; i++) begin
            x_dly_q[i] <= '0;
            y_dly_q[i] <= '0;
          end
        end else begin
          x_dly_q[0] <= x_pixel;
          y_dly_q[0] <= y_pixel;
          for (int i = 1; i < LATENCY; i++) begin
            x_dly_q[i] <= x_dly_q[i-1];
            y_dly_q[i] <= y_dly_q[i-1];
          end
        end
      end
      assign xd = x_dly_q[LATENCY-1];
      assign yd = y_dly_q[LATENCY-1];
    end
  endgenerate

  logic              accept;
  logic [IDX_W-1:0]  bit_idx;
  logic              last_bit;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] word_addr;

  assign accept    = in_valid && (xd < H_LIM) && (yd < V_LIM);
  assign bit_idx   = IDX_W'(xd % WORD_C);
  assign last_bit  = (bit_idx == IDX_W'(WORD_W - 1));
  assign word_addr = ADDR_W'(yd) * WPL_C + ADDR_W'(xd / WORD_C);

  // Bit 0 starts a fresh word so stale bits from an unfinished word never leak.
  always_comb begin
    word          = (bit_idx == '0) ? '0 : acc_q;
    word[bit_idx] = sdata;
    acc_d         = acc_q;
    if (accept) acc_d = last_bit ? '0 : word;
  end

  logic              stg_vld_q;
  logic [ADDR_W-1:0] stg_addr_q;
  logic [WORD_W-1:0] stg_data_q;

  // Completed-word stage between the packer and the queue.
  always_ff @(posedge pclk) begin
    if (reset) begin
      acc_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_addr_q <= '0;
      stg_data_q <= '0;
    end else begin
      acc_q     <= acc_d;
      stg_vld_q <= accept && last_bit;
      if (accept && last_bit) begin
        stg_addr_q <= word_addr;
        stg_data_q <= word;
      end
    end
  end

  logic [ADDR_W-1:0] q_addr_q [2];
  logic [WORD_W-1:0] q_data_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              wr_en_q, overflow_q, frame_done_q;
  logic              pop, push, drop;

  assign pop  = wr_en_q && wr_ready;
  assign push = stg_vld_q && ((cnt_q != 2'd2) || pop);
  assign drop = stg_vld_q && (cnt_q == 2'd2) && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  // When full, a simultaneous push lands in the slot the head is vacating.
  always_ff @(posedge pclk) begin
    if (reset) begin
      cnt_q        <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      wr_en_q <= (cnt_d != 2'd0);
      if (push) begin
        q_addr_q[wr_ptr_q] <= stg_addr_q;
        q_data_q[wr_ptr_q] <= stg_data_q;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop)  rd_ptr_q   <= ~rd_ptr_q;
      if (drop) overflow_q <= 1'b1;
      frame_done_q <= pop && (wr_addr == LAST_ADDR);
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = q_addr_q[rd_ptr_q];
  assign wr_data    = q_data_q[rd_ptr_q];
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_edge_mask_writer.sv
// Self-checking bench for edge_mask_writer: pixel stream driver, word-level
// reference model and a write-port monitor.
module tb_edge_mask_writer;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int W  = 16;
  localparam int AW = 15;

  logic          pclk     = 1'b0;
  logic          reset    = 1'b0;
  logic [9:0]    x_pixel  = '0;
  logic [9:0]    y_pixel  = '0;
  logic          in_valid = 1'b0;
  logic          sdata    = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          frame_done;
  logic          overflow;

  edge_mask_writer #(
    .H_RES(H), .V_RES(V), .WORD_W(W), .ADDR_W(AW), .LATENCY(1)
  ) dut (
    .pclk(pclk), .reset(reset), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .in_valid(in_valid), .sdata(sdata), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 pclk = ~pclk;

  int errors  = 0;
  int checks  = 0;
  int cyc_cnt = 0;
  always @(posedge pclk) cyc_cnt++;

  // Reference model state: pixel waiting for its sdata, pending word bits, expected writes.
  int            px = 0, py = 0;
  bit            pv = 1'b0, ps = 1'b0;
  bit            pend [W];
  logic [AW-1:0] exp_addr [$];
  logic [W-1:0]  exp_data [$];

  // Monitor logs.
  logic [AW-1:0] got_addr [$];
  logic [W-1:0]  got_data [$];
  int            got_cyc  [$];
  int            fd_cyc   [$];
  int            run_len = 0, run_max = 0;
  bit            hold_prev = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [W-1:0]  hold_data;

  always @(negedge pclk) begin
    if (!reset) begin
      if (wr_en === 1'b1 && wr_ready) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
        got_cyc.push_back(cyc_cnt);
      end
      if (wr_en === 1'b1) run_len++;
      else run_len = 0;
      if (run_len > run_max) run_max = run_len;
      if (frame_done === 1'b1) fd_cyc.push_back(cyc_cnt);
      if (hold_prev) begin
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== hold_addr || wr_data !== hold_data) begin
          errors++;
          $display("FAIL stall_hold: got wr_en=%b addr=%0d data=%h, expected wr_en=1 addr=%0d data=%h",
                   wr_en, wr_addr, wr_data, hold_addr, hold_data);
        end
      end
      hold_prev = (wr_en === 1'b1) && !wr_ready;
      hold_addr = wr_addr;
      hold_data = wr_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic model_pixel(input int x, input int y, input bit v, input bit s);
    logic [W-1:0] w;
    if (!v || x >= H || y >= V) return;
    if (x % W == 0) for (int i = 0; i < W; i++) pend[i] = 1'b0;
    pend[x % W] = s;
    if (x % W == W - 1) begin
      for (int i = 0; i < W; i++) w[i] = pend[i];
      exp_addr.push_back(AW'(y * (H / W) + x / W));
      exp_data.push_back(w);
      for (int i = 0; i < W; i++) pend[i] = 1'b0;
    end
  endtask

  // One pixel clock: new coordinates now, sdata/in_valid of the previous pixel.
  task automatic step(input int x, input int y, input bit v, input bit s, input bit rdy);
    x_pixel  = 10'(x);
    y_pixel  = 10'(y);
    in_valid = pv;
    sdata    = ps;
    wr_ready = rdy;
    model_pixel(px, py, pv, ps);
    px = x; py = y; pv = v; ps = s;
    @(posedge pclk); #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(800, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic apply_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    sdata    = 1'b0;
    x_pixel  = '0;
    y_pixel  = '0;
    repeat (n) @(posedge pclk);
    #1;
    reset = 1'b0;
    pv = 1'b0; ps = 1'b0; px = 0; py = 0;
    for (int i = 0; i < W; i++) pend[i] = 1'b0;
  endtask

  task automatic clear_logs();
    exp_addr.delete(); exp_data.delete();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    run_max = 0;
  endtask

  task automatic test_reset();
    wr_ready = 1'b0;
    apply_reset(2);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_line_ones();
    int c0;
    c0 = 0;
    clear_logs();
    for (int x = 0; x < H; x++) begin
      if (x == 16) c0 = cyc_cnt;
      step(x, 0, 1'b1, 1'b1, 1'b1);
    end
    drain(30);
    checks++;
    if (got_addr.size() != 40) begin errors++; $display("FAIL ones_count: got %0d writes expected 40", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < 40; i++) begin
      checks++;
      if (got_addr[i] !== AW'(i) || got_data[i] !== 16'hFFFF) begin
        errors++;
        $display("FAIL ones_word%0d: got addr=%0d data=%h expected addr=%0d data=ffff", i, got_addr[i], got_data[i], i);
      end
    end
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] != c0 + 2) begin
      errors++;
      $display("FAIL ones_latency: first transfer cycle %0d expected %0d", got_cyc.size() ? got_cyc[0] : -1, c0 + 2);
    end
    checks++;
    if (run_max != 1) begin errors++; $display("FAIL ones_wr_en_run: got %0d consecutive cycles expected 1", run_max); end
  endtask

  task automatic test_alternating();
    clear_logs();
    for (int x = 0; x < H; x++) step(x, 3, 1'b1, x[0], 1'b1);
    for (int x = H; x < 800; x++) step(x, 3, 1'b1, 1'b1, 1'b1);
    for (int x = 0; x < 32; x++) step(x, 500, 1'b1, 1'b1, 1'b1);
    drain(30);
    checks++;
    if (got_addr.size() != 40) begin errors++; $display("FAIL alt_count: got %0d writes expected 40", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < 40; i++) begin
      checks++;
      if (got_addr[i] !== AW'(120 + i) || got_data[i] !== 16'hAAAA) begin
        errors++;
        $display("FAIL alt_word%0d: got addr=%0d data=%h expected addr=%0d data=aaaa", i, got_addr[i], got_data[i], 120 + i);
      end
    end
  endtask

  task automatic test_stall();
    clear_logs();
    for (int x = 0; x < H; x++) begin
      step(x, 0, 1'b1, 1'($urandom % 2), !(x >= 16 && x < 36));
      if (x == 35) begin
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== exp_data[0]) begin
          errors++;
          $display("FAIL stall_head: got wr_en=%b addr=%0d data=%h expected 1/0/%h", wr_en, wr_addr, wr_data, exp_data[0]);
        end
        checks++;
        if (overflow !== 1'b0 || got_addr.size() != 0) begin
          errors++;
          $display("FAIL stall_state: got overflow=%b writes=%0d expected 0/0", overflow, got_addr.size());
        end
      end
    end
    drain(30);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL stall_count: got %0d writes expected %0d", got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL stall_word%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (got_cyc.size() < 2 || got_cyc[1] != got_cyc[0] + 1) begin
      errors++; $display("FAIL stall_back_to_back: second write not in the cycle after the first");
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL stall_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_random();
    int y;
    clear_logs();
    for (int l = 0; l < 2; l++) begin
      y = int'($urandom_range(0, 470));
      for (int x = 0; x < H; x++)
        step(x, y, ($urandom % 8) != 0, 1'($urandom % 2), ($urandom % 4) != 0);
      drain(5);
    end
    drain(40);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL rand_count: got %0d writes expected %0d", got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL rand_word%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_logs();
    for (int i = 0; i < 100; i++)
      step((i < 48) ? i : 700, 0, i < 48, 1'($urandom % 2), !(i >= 12 && i < 52));
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++;
    if (got_addr.size() != 2) begin errors++; $display("FAIL ovf_count: got %0d writes expected 2", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < 2; i++) begin
      checks++;
      if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL ovf_word%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
    drain(20);
    checks++;
    if (overflow !== 1'b1 || got_addr.size() != 2) begin
      errors++; $display("FAIL ovf_sticky: got overflow=%b writes=%0d expected 1/2", overflow, got_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    for (int x = 0; x <= 8; x++) step(x, 5, 1'b1, 1'b1, 1'b1);
    apply_reset(1);
    checks++;
    if (wr_en !== 1'b0 || overflow !== 1'b0 || wr_addr !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got wr_en=%b overflow=%b addr=%0d expected 0/0/0", wr_en, overflow, wr_addr);
    end
    clear_logs();
    for (int x = 0; x < H; x++) step(x, 6, 1'b1, 1'($urandom % 2), 1'b1);
    drain(30);
    checks++;
    if (got_addr.size() != 40) begin errors++; $display("FAIL rstmid_count: got %0d writes expected 40", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < 40 && i < exp_data.size(); i++) begin
      checks++;
      if (got_addr[i] !== AW'(240 + i) || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL rstmid_word%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, got_addr[i], got_data[i], 240 + i, exp_data[i]);
      end
    end
  endtask

  task automatic test_frame_end();
    clear_logs();
    for (int y = 478; y < V; y++) begin
      for (int x = 0; x < H; x++) step(x, y, 1'b1, (x == H - 1) && (y == V - 1), 1'b1);
      drain(10);
    end
    drain(30);
    checks++;
    if (got_addr.size() != 80) begin errors++; $display("FAIL frame_count: got %0d writes expected 80", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL frame_word%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (got_addr.size() == 0 || got_addr[$] !== AW'(19199) || got_data[$] !== 16'h8000) begin
      errors++; $display("FAIL frame_last_word: last write not addr=19199 data=8000");
    end
    checks++;
    if (fd_cyc.size() != 1) begin errors++; $display("FAIL frame_done_count: got %0d pulse cycles expected 1", fd_cyc.size()); end
    checks++;
    if (fd_cyc.size() == 0 || got_cyc.size() == 0 || fd_cyc[0] != got_cyc[$] + 1) begin
      errors++; $display("FAIL frame_done_timing: pulse not in the cycle after the last transfer");
    end
  endtask

  initial begin
    test_reset();
    test_line_ones();
    test_alternating();
    test_stall();
    test_random();
    test_overflow();
    test_reset_mid();
    test_frame_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
